// File: rtl/cpu_if_stage.sv
// 6502 instruction fetch: byte-serial reads, opcode length decode, one assembled
// instruction per valid/ready handshake. Optional macro IF_ILLEGAL_TRAP_EN flags cc==11 opcodes.
module cpu_if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  output logic        inst_illegal,
  input  logic        br_taken,
  input  logic [15:0] br_target
);

  typedef enum logic [1:0] {S_REQ, S_CAP, S_OUT} state_t;

  state_t      state;
  logic [15:0] fetch_pc;
  logic [15:0] pc_next;
  logic [15:0] pc_cap;
  logic [1:0]  idx;
  logic [1:0]  len;
  logic [1:0]  dec_len;
  logic [1:0]  cur_len;
  logic        more;
  logic [7:0]  byte0;
  logic [7:0]  byte1;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    bbb = op[4:2];
    cc  = op[1:0];
`ifdef IF_ILLEGAL_TRAP_EN
    if (cc == 2'b11) return 2'd1;
`else
    // Undocumented cc==11 opcodes follow the ALU-group (cc==01) addressing modes.
    if (cc == 2'b11) cc = 2'b01;
`endif
    if (bbb == 3'd3 || bbb == 3'd7 || (cc == 2'b01 && bbb == 3'd6) || op == 8'h20)
      return 2'd3;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60 ||
        (cc != 2'b01 && (bbb == 3'd2 || bbb == 3'd6)))
      return 2'd1;
    return 2'd2;
  endfunction

  assign pc_next = fetch_pc + 16'd1;
  assign dec_len = decode_len(mem_rdata);
  assign cur_len = (idx == 2'd0) ? dec_len : len;
  assign more    = ({1'b0, idx} + 3'd1) < {1'b0, cur_len};

`ifdef IF_ILLEGAL_TRAP_EN
  logic dec_ill;
  logic ill_cap;
  assign dec_ill = (mem_rdata[1:0] == 2'b11);
`else
  assign inst_illegal = 1'b0;
`endif

  // Control and output holding registers; mem_rd is raised on every entry to S_REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      idx         <= 2'd0;
      len         <= 2'd0;
      mem_rd      <= 1'b0;
      mem_addr    <= 16'h0000;
      inst_valid  <= 1'b0;
      inst_opcode <= 8'h00;
      inst_op1    <= 8'h00;
      inst_op2    <= 8'h00;
      inst_len    <= 2'd0;
      inst_pc     <= 16'h0000;
`ifdef IF_ILLEGAL_TRAP_EN
      inst_illegal <= 1'b0;
`endif
    end else if (br_taken) begin
      state      <= S_REQ;
      fetch_pc   <= br_target;
      idx        <= 2'd0;
      mem_rd     <= 1'b1;
      mem_addr   <= br_target;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // Only the first cycle after reset arrives here without a read in flight.
          if (mem_rd) begin
            mem_rd <= 1'b0;
            state  <= S_CAP;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        S_CAP: begin
          fetch_pc <= pc_next;
          if (idx == 2'd0) len <= dec_len;
          if (more) begin
            idx      <= idx + 2'd1;
            state    <= S_REQ;
            mem_rd   <= 1'b1;
            mem_addr <= pc_next;
          end else begin
            state       <= S_OUT;
            inst_valid  <= 1'b1;
            inst_opcode <= (idx == 2'd0) ? mem_rdata : byte0;
            inst_op1    <= (idx == 2'd0) ? 8'h00 : ((idx == 2'd1) ? mem_rdata : byte1);
            inst_op2    <= (idx == 2'd2) ? mem_rdata : 8'h00;
            inst_len    <= cur_len;
            inst_pc     <= (idx == 2'd0) ? fetch_pc : pc_cap;
`ifdef IF_ILLEGAL_TRAP_EN
            inst_illegal <= (idx == 2'd0) ? dec_ill : ill_cap;
`endif
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            idx        <= 2'd0;
            state      <= S_REQ;
            mem_rd     <= 1'b1;
            mem_addr   <= fetch_pc;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Partial instruction bytes; stale contents are never presented, so no reset.
  always_ff @(posedge clk) begin
    if (!br_taken && state == S_CAP) begin
      case (idx)
        2'd0: begin
          byte0  <= mem_rdata;
          pc_cap <= fetch_pc;
`ifdef IF_ILLEGAL_TRAP_EN
          ill_cap <= dec_ill;
`endif
        end
        2'd1: byte1 <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_if_stage.sv
// Directed bench for cpu_if_stage with a 1-cycle synchronous program memory model.
module tb_cpu_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [7:0]  inst_op1;
  logic [7:0]  inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        inst_illegal;
  logic        br_taken;
  logic [15:0] br_target;

  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_pass   = 0;

  cpu_if_stage #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_op1(inst_op1), .inst_op2(inst_op2),
    .inst_len(inst_len), .inst_pc(inst_pc), .inst_illegal(inst_illegal),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!inst_valid && cyc < 64);
  endtask

  task automatic check_inst(input string tag, input logic [7:0] op, input logic [7:0] o1,
                            input logic [7:0] o2, input logic [1:0] ln, input logic [15:0] pc,
                            input logic ill, input int lat_got, input int lat_exp);
    check({tag, ".valid"},  64'(inst_valid),   64'(1'b1));
    check({tag, ".opcode"}, 64'(inst_opcode),  64'(op));
    check({tag, ".op1"},    64'(inst_op1),     64'(o1));
    check({tag, ".op2"},    64'(inst_op2),     64'(o2));
    check({tag, ".len"},    64'(inst_len),     64'(ln));
    check({tag, ".pc"},     64'(inst_pc),      64'(pc));
    check({tag, ".illegal"}, 64'(inst_illegal), 64'(ill));
    check({tag, ".latency"}, 64'(lat_got),     64'(lat_exp));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"},   64'(inst_valid),   64'(1'b0));
    check({tag, ".opcode"},  64'(inst_opcode),  64'(8'h00));
    check({tag, ".op1"},     64'(inst_op1),     64'(8'h00));
    check({tag, ".op2"},     64'(inst_op2),     64'(8'h00));
    check({tag, ".len"},     64'(inst_len),     64'(2'd0));
    check({tag, ".pc"},      64'(inst_pc),      64'(16'h0000));
    check({tag, ".illegal"}, 64'(inst_illegal), 64'(1'b0));
    check({tag, ".mem_rd"},  64'(mem_rd),       64'(1'b0));
    check({tag, ".mem_addr"}, 64'(mem_addr),    64'(16'h0000));
  endtask

  task automatic check_read(input string tag, input logic [15:0] addr);
    check({tag, ".mem_rd"},   64'(mem_rd),   64'(1'b1));
    check({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr));
  endtask

  // Pulses br_taken over one rising edge; returns at the following falling edge.
  task automatic redirect(input logic [15:0] target);
    br_taken  = 1'b1;
    br_target = target;
    @(negedge clk);
    br_taken  = 1'b0;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0100] = 8'hA0; mem[16'h0101] = 8'h00;
    mem[16'h0102] = 8'h84; mem[16'h0103] = 8'h32;
    mem[16'h0104] = 8'hB1; mem[16'h0105] = 8'h1E;
    mem[16'h0106] = 8'hAA;
    mem[16'h0107] = 8'hA9; mem[16'h0108] = 8'h55;
    mem[16'h010E] = 8'h90; mem[16'h010F] = 8'h18;
    mem[16'h0123] = 8'h24; mem[16'h0124] = 8'h32;
    mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h10;
    mem[16'h0000] = 8'hAA; mem[16'h0001] = 8'hAD;
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h11; mem[16'h0302] = 8'h22;

    rst_n      = 1'b0;
    inst_ready = 1'b1;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // Straight-line program from RESET_PC with ready held high.
    rst_n = 1'b1;
    @(negedge clk);
    check_read("first_rd", 16'h0100);
    wait_valid(c);
    check_inst("i0", 8'hA0, 8'h00, 8'h00, 2'd2, 16'h0100, 1'b0, c + 1, 5);
    wait_valid(c);
    check_inst("i1", 8'h84, 8'h32, 8'h00, 2'd2, 16'h0102, 1'b0, c, 5);
    wait_valid(c);
    check_inst("i2", 8'hB1, 8'h1E, 8'h00, 2'd2, 16'h0104, 1'b0, c, 5);
    wait_valid(c);
    check_inst("i3", 8'hAA, 8'h00, 8'h00, 2'd1, 16'h0106, 1'b0, c, 3);

    // Backpressure on the AA instruction.
    inst_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp.hold", 64'({inst_valid, inst_opcode, inst_op1, inst_op2, inst_len, inst_pc}),
            64'({1'b1, 8'hAA, 8'h00, 8'h00, 2'd1, 16'h0106}));
      check("bp.no_rd", 64'(mem_rd), 64'(1'b0));
    end
    inst_ready = 1'b1;
    @(negedge clk);
    check_read("bp.next", 16'h0107);
    wait_valid(c);
    check_inst("i4", 8'hA9, 8'h55, 8'h00, 2'd2, 16'h0107, 1'b0, c + 1, 5);

    // Redirect while the next opcode read is in flight.
    @(negedge clk);
    redirect(16'h0200);
    check("jmp.valid_drop", 64'(inst_valid), 64'(1'b0));
    check_read("jmp.rd", 16'h0200);
    wait_valid(c);
    check_inst("jmp", 8'h4C, 8'h34, 8'h12, 2'd3, 16'h0200, 1'b0, c + 1, 7);

    // Redirect coinciding with a handshake, then a second redirect mid operand fetch.
    redirect(16'h010E);
    check("hs_br.valid_drop", 64'(inst_valid), 64'(1'b0));
    check_read("hs_br.rd", 16'h010E);
    repeat (2) @(negedge clk);
    check_read("bcc.op_rd", 16'h010F);
    redirect(16'h0123);
    check("bcc.valid", 64'(inst_valid), 64'(1'b0));
    check_read("bcc.redir_rd", 16'h0123);
    wait_valid(c);
    check_inst("bit", 8'h24, 8'h32, 8'h00, 2'd2, 16'h0123, 1'b0, c + 1, 5);

    // Address wrap across 0xFFFF.
    redirect(16'hFFFE);
    wait_valid(c);
    check_inst("wrap", 8'hAD, 8'h10, 8'hAA, 2'd3, 16'hFFFE, 1'b0, c + 1, 7);
    @(negedge clk);
    check_read("wrap.next", 16'h0001);

    // Reset pulse during the second capture of a 3-byte instruction at 0x0001.
    @(negedge clk);
    @(negedge clk);
    check_read("mid.op_rd", 16'h0002);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_read("mid_rst.rd", 16'h0100);
    wait_valid(c);
    check_inst("after_rst", 8'hA0, 8'h00, 8'h00, 2'd2, 16'h0100, 1'b0, c + 1, 5);

    // cc==11 opcode handling.
    redirect(16'h0300);
    wait_valid(c);
`ifdef IF_ILLEGAL_TRAP_EN
    check_inst("illegal", 8'hFF, 8'h00, 8'h00, 2'd1, 16'h0300, 1'b1, c + 1, 3);
`else
    check_inst("illegal", 8'hFF, 8'h11, 8'h22, 2'd3, 16'h0300, 1'b0, c + 1, 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
